// File: rtl/flap_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// flap_ctrl_pkg
// Shared constants and types for the flap input conditioner.
//   DEFAULT_*_LEN : parameter defaults for flap_ctrl / key_debounce
//   flap_state_t  : burst FSM state encoding
//   max2()        : elaboration-time helper for counter sizing
// No ports (package).
// ---------------------------------------------------------------------------
package flap_ctrl_pkg;

  localparam int DEFAULT_DEBOUNCE_LEN = 4;
  localparam int DEFAULT_FLAP_LEN     = 16;
  localparam int DEFAULT_COOLDOWN_LEN = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    COOL = 2'd2
  } flap_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/flap_ctrl_if.sv
// ---------------------------------------------------------------------------
// flap_ctrl_if
// Groups the player-facing and bird-facing signals of flap_ctrl.
//   key_n  : raw push-button, active-low, asynchronous to clk
//   enable : game running; low forces the controller idle
//   up     : registered climb command to the bird stage
//   busy   : registered, high whenever the burst FSM is not idle
// Modports:
//   master : environment side (drives key_n/enable, observes up/busy)
//   slave  : flap_ctrl side
// ---------------------------------------------------------------------------
interface flap_ctrl_if;

  logic key_n;
  logic enable;
  logic up;
  logic busy;

  modport master (
    output key_n,
    output enable,
    input  up,
    input  busy
  );

  modport slave (
    input  key_n,
    input  enable,
    output up,
    output busy
  );

endinterface

// File: rtl/flap_ctrl_key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Synchronizes an active-low asynchronous push-button, debounces it and
// produces a one-cycle press pulse on each accepted high->low transition of
// the debounced level. Reusable for any panel button (flap, restart).
// Ports:
//   clk    in   game tick clock
//   reset  in   synchronous, active-high
//   key_n  in   raw push-button, active-low, asynchronous
//   press  out  one-cycle pulse when the debounced level falls
// Parameters:
//   DEBOUNCE_LEN : cycles a new synchronized level must persist (>=1)
// ---------------------------------------------------------------------------
module key_debounce
  import flap_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_LEN = DEFAULT_DEBOUNCE_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int DCW = (DEBOUNCE_LEN > 1) ? $clog2(DEBOUNCE_LEN) : 1;
  localparam logic [DCW-1:0] DB_TERM = DCW'(DEBOUNCE_LEN - 1);

  logic           s1;
  logic           s2;
  logic           db;
  logic           db_prev;
  logic [DCW-1:0] db_cnt;

  // Everything resets to the released level so a key held through reset
  // is seen as a fresh press once it has been debounced again.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1      <= 1'b1;
      s2      <= 1'b1;
      db      <= 1'b1;
      db_prev <= 1'b1;
      db_cnt  <= '0;
    end else begin
      s1      <= key_n;
      s2      <= s1;
      db_prev <= db;
      if (s2 == db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_TERM) begin
        // This cycle is the DEBOUNCE_LEN-th consecutive mismatch.
        db     <= s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign press = db_prev & ~db;

endmodule

// File: rtl/flap_ctrl.sv
// ---------------------------------------------------------------------------
// flap_ctrl
// Turns the player's raw push-button into the bird's `up` command: each
// accepted press yields a FLAP_LEN-cycle climb burst followed by a
// COOLDOWN_LEN-cycle cooldown during which presses are dropped.
// Ports:
//   clk    in   game tick clock
//   reset  in   synchronous, active-high
//   bus    flap_ctrl_if.slave
//            key_n  in   raw push-button, active-low, asynchronous
//            enable in   game running; low forces IDLE next edge
//            up     out  climb command, registered (state == RISE)
//            busy   out  registered (state != IDLE)
// Parameters:
//   DEBOUNCE_LEN (>=1), FLAP_LEN (>=1), COOLDOWN_LEN (>=0, 0 skips COOL)
// Build option:
//   FLAP_RETRIGGER_EN - when defined, a press during RISE restarts the
//   burst (phase counter back to 0, up stays high). Presses during COOL
//   are ignored in either build.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for press & enable
// RISE  | climb burst, up high, FLAP_LEN cycles
// COOL  | cooldown, presses dropped, COOLDOWN_LEN cycles
// ---------------------------------------------------------------------------
module flap_ctrl
  import flap_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_LEN = DEFAULT_DEBOUNCE_LEN,
  parameter int FLAP_LEN     = DEFAULT_FLAP_LEN,
  parameter int COOLDOWN_LEN = DEFAULT_COOLDOWN_LEN
) (
  input  logic        clk,
  input  logic        reset,
  flap_ctrl_if.slave  bus
);

  localparam int CNT_MAX = max2(FLAP_LEN, COOLDOWN_LEN);
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] FLAP_TERM = CW'(FLAP_LEN - 1);
  // Unused when COOLDOWN_LEN == 0 (COOL is never entered); kept in range.
  localparam logic [CW-1:0] COOL_TERM =
    CW'((COOLDOWN_LEN > 0) ? (COOLDOWN_LEN - 1) : 0);

  logic          press;
  logic          retrig;
  flap_state_t   state_q;
  flap_state_t   state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          up_q;
  logic          busy_q;

  key_debounce #(
    .DEBOUNCE_LEN (DEBOUNCE_LEN)
  ) u_key_debounce (
    .clk   (clk),
    .reset (reset),
    .key_n (bus.key_n),
    .press (press)
  );

`ifdef FLAP_RETRIGGER_EN
  assign retrig = press;
`else
  assign retrig = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      up_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Outputs are registered from the next state so they line up with
      // state_q exactly, without an extra cycle of latency.
      up_q    <= (state_d == RISE);
      busy_q  <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!bus.enable) begin
      // Game paused: drop everything, including a press arriving now.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (press) begin
            state_d = RISE;
            cnt_d   = '0;
          end
        end
        RISE: begin
          if (retrig) begin
            cnt_d = '0;
          end else if (cnt_q == FLAP_TERM) begin
            cnt_d = '0;
            if (COOLDOWN_LEN == 0) begin
              state_d = IDLE;
            end else begin
              state_d = COOL;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        COOL: begin
          if (cnt_q == COOL_TERM) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign bus.up   = up_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_flap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_flap_ctrl
// Directed bench for flap_ctrl with default parameters. Each test pushes the
// expected output changes ({up,busy} and the edge number after which they
// appear, counted from the reset edge) into a scoreboard queue; a monitor
// on the falling edge pops an entry whenever {up,busy} changes.
// Honors FLAP_RETRIGGER_EN for the retrigger scenario.
// ---------------------------------------------------------------------------
module tb_flap_ctrl;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  flap_ctrl_if bus ();

  flap_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int         cyc;
    logic [1:0] ub;
  } ev_t;

  ev_t        sb[$];
  int         total  = 0;
  int         bad    = 0;
  int         cyc    = 0;
  int         base   = 0;
  bit         mon_on = 1'b0;
  logic [1:0] prev   = 2'b00;
  logic [1:0] cur;
  ev_t        got_ev;
  string      tname  = "reset";

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every change of {up,busy} must match the next expected event.
  always @(negedge clk) begin
    if (mon_on) begin
      cur = {bus.up, bus.busy};
      if (cur !== prev) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL %s_unexpected got edge=%0d up/busy=%b required no change",
                   tname, cyc - base, cur);
        end else begin
          got_ev = sb.pop_front();
          if (got_ev.cyc != cyc || got_ev.ub !== cur) begin
            bad++;
            $display("FAIL %s_event got edge=%0d up/busy=%b required edge=%0d up/busy=%b",
                     tname, cyc - base, cur, got_ev.cyc - base, got_ev.ub);
          end
        end
        prev = cur;
      end
    end
  end

  task automatic expect_ev(input int k, input logic u, input logic b);
    ev_t e;
    e.cyc = base + k;
    e.ub  = {u, b};
    sb.push_back(e);
  endtask

  // Return #1 after edge k (relative to the reset edge).
  task automatic at_edge(input int k);
    int n;
    n = base + k - cyc;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.key_n  = 1'b1;
    bus.enable = 1'b1;
    reset      = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    base  = cyc;
  endtask

  task automatic chk(input string n, input logic [1:0] got, input logic [1:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got up/busy=%b required up/busy=%b", n, got, req);
    end
  endtask

  task automatic end_test();
    @(negedge clk);
    chk({tname, "_final"}, {bus.up, bus.busy}, 2'b00);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_pending got %0d events outstanding required 0",
               tname, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    bus.key_n  = 1'b1;
    bus.enable = 1'b1;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("reset_up_busy", {bus.up, bus.busy}, 2'b00);
    prev   = 2'b00;
    mon_on = 1'b1;

    // T1: idle, key released
    tname = "idle";
    do_reset();
    at_edge(50);
    end_test();

    // T2: single held press, exactly one burst then cooldown
    tname = "held_press";
    do_reset();
    expect_ev(7, 1'b1, 1'b1);
    expect_ev(23, 1'b0, 1'b1);
    expect_ev(31, 1'b0, 1'b0);
    bus.key_n = 1'b0;
    at_edge(40);
    bus.key_n = 1'b1;
    at_edge(55);
    end_test();

    // T3: 3-cycle glitch, one short of the debounce length
    tname = "glitch";
    do_reset();
    bus.key_n = 1'b0;
    at_edge(3);
    bus.key_n = 1'b1;
    at_edge(30);
    end_test();

    // T4a: second press registered at edge 15, during RISE
    tname = "press_in_rise";
    do_reset();
    expect_ev(7, 1'b1, 1'b1);
`ifdef FLAP_RETRIGGER_EN
    expect_ev(31, 1'b0, 1'b1);
    expect_ev(39, 1'b0, 1'b0);
`else
    expect_ev(23, 1'b0, 1'b1);
    expect_ev(31, 1'b0, 1'b0);
`endif
    bus.key_n = 1'b0;
    at_edge(4);
    bus.key_n = 1'b1;
    at_edge(8);
    bus.key_n = 1'b0;
    at_edge(45);
    bus.key_n = 1'b1;
    at_edge(60);
    end_test();

    // T4b: second press registered at edge 25, during COOL
    tname = "press_in_cool";
    do_reset();
    expect_ev(7, 1'b1, 1'b1);
    expect_ev(23, 1'b0, 1'b1);
    expect_ev(31, 1'b0, 1'b0);
    bus.key_n = 1'b0;
    at_edge(4);
    bus.key_n = 1'b1;
    at_edge(18);
    bus.key_n = 1'b0;
    at_edge(45);
    bus.key_n = 1'b1;
    at_edge(60);
    end_test();

    // T5: enable handling
    tname = "enable";
    do_reset();
    expect_ev(7, 1'b1, 1'b1);
    expect_ev(11, 1'b0, 1'b0);   // enable dropped mid-RISE
    expect_ev(68, 1'b1, 1'b1);   // press and enable rise together
    expect_ev(84, 1'b0, 1'b1);
    expect_ev(92, 1'b0, 1'b0);
    bus.key_n = 1'b0;
    at_edge(10);
    bus.enable = 1'b0;
    at_edge(11);
    bus.key_n = 1'b1;
    at_edge(20);
    bus.enable = 1'b1;           // re-enable, key released: nothing
    at_edge(30);
    bus.enable = 1'b0;
    at_edge(40);
    bus.key_n = 1'b0;            // press lands at edge 47 while disabled
    at_edge(50);
    bus.enable = 1'b1;           // key still held: no new press
    at_edge(54);
    bus.key_n = 1'b1;
    at_edge(60);
    bus.enable = 1'b0;
    at_edge(61);
    bus.key_n = 1'b0;            // press pulse sampled at edge 68
    at_edge(67);
    bus.enable = 1'b1;
    at_edge(100);
    bus.key_n = 1'b1;
    at_edge(110);
    end_test();

    // T6: one-cycle reset mid-COOL with key held
    tname = "reset_mid_cool";
    do_reset();
    expect_ev(7, 1'b1, 1'b1);
    expect_ev(23, 1'b0, 1'b1);
    expect_ev(26, 1'b0, 1'b0);
    expect_ev(33, 1'b1, 1'b1);
    expect_ev(49, 1'b0, 1'b1);
    expect_ev(57, 1'b0, 1'b0);
    bus.key_n = 1'b0;
    at_edge(25);
    reset = 1'b1;
    at_edge(26);
    reset = 1'b0;
    at_edge(65);
    bus.key_n = 1'b1;
    at_edge(75);
    end_test();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
